// File: rtl/id_hazard_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight writes, stalls on
// RAW hazards and full per-register counters, reports busy/stall stats.
module id_hazard_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         src1,
  input  logic               src1_used,
  input  logic [4:0]         src2,
  input  logic               src2_used,
  input  logic [4:0]         dest,
  input  logic               wb_en,
  input  logic               flush,
  input  logic               ret_valid,
  input  logic [4:0]         ret_dest,
  output logic               stall,
  output logic               issue,
  output logic [31:0]        busy,
  output logic [6:0]         inflight,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               err
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] pend [32];

  logic [CNT_W-1:0] p1, p2, pd, pr;
  logic             hit1, hit2;
  logic             raw1, raw2, sat;
  logic [31:0]      inc_v, dec_v;

  assign p1 = pend[src1];
  assign p2 = pend[src2];
  assign pd = pend[dest];
  assign pr = pend[ret_dest];

  // Write-back lands on the falling edge, so a same-cycle retire
  // already satisfies one outstanding write for the reader.
  assign hit1 = ret_valid && (ret_dest == src1);
  assign hit2 = ret_valid && (ret_dest == src2);

  assign raw1 = src1_used && (src1 != 5'd0)
             && (p1 > CNT_W'(hit1));
  assign raw2 = src2_used && (src2 != 5'd0)
             && (p2 > CNT_W'(hit2));

  assign sat = wb_en && (dest != 5'd0) && (pd == CMAX);

  assign stall = id_valid && !flush && (raw1 || raw2 || sat);
  assign issue = id_valid && !flush && !stall;

  always_comb begin
    busy     = '0;
    inflight = '0;
    inc_v    = '0;
    dec_v    = '0;
    for (int r = 1; r < 32; r++) begin
      busy[r]  = (pend[r] != '0);
      inflight = inflight + 7'(pend[r]);
      inc_v[r] = issue && wb_en && (dest == 5'(r));
      dec_v[r] = ret_valid && (ret_dest == 5'(r))
              && (pend[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++)
        pend[r] <= '0;
      err          <= 1'b0;
      stall_cycles <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_v[r] && !dec_v[r])
          pend[r] <= pend[r] + ONE;
        else if (dec_v[r] && !inc_v[r])
          pend[r] <= pend[r] - ONE;
      end
      if (ret_valid && (ret_dest != 5'd0) && (pr == '0))
        err <= 1'b1;
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: a per-cycle vector table
// plus a hand-written multi-cycle stall sequence.
module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  src1;
  logic        src1_used;
  logic [4:0]  src2;
  logic        src2_used;
  logic [4:0]  dest;
  logic        wb_en;
  logic        flush;
  logic        ret_valid;
  logic [4:0]  ret_dest;
  logic        stall;
  logic        issue;
  logic [31:0] busy;
  logic [6:0]  inflight;
  logic [15:0] stall_cycles;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_scoreboard #(.CNT_W(2), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .src1(src1), .src1_used(src1_used),
    .src2(src2), .src2_used(src2_used),
    .dest(dest), .wb_en(wb_en), .flush(flush),
    .ret_valid(ret_valid), .ret_dest(ret_dest),
    .stall(stall), .issue(issue), .busy(busy),
    .inflight(inflight), .stall_cycles(stall_cycles),
    .err(err)
  );

  typedef struct {
    logic        rst;
    logic        idv;
    logic [4:0]  s1;
    logic        s1u;
    logic [4:0]  s2;
    logic        s2u;
    logic [4:0]  d;
    logic        wb;
    logic        fl;
    logic        rv;
    logic [4:0]  rd;
    logic        e_stall;
    logic        e_issue;
    logic [31:0] e_busy;
    logic [6:0]  e_infl;
    logic [15:0] e_sc;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    int rs, int iv, int a, int au, int b, int bu,
    int d, int w, int f, int rv, int rd,
    int es, int ei, int eb, int en, int ec, int ee);
    vec_t v;
    v.rst = 1'(rs);  v.idv = 1'(iv);
    v.s1 = 5'(a);    v.s1u = 1'(au);
    v.s2 = 5'(b);    v.s2u = 1'(bu);
    v.d = 5'(d);     v.wb = 1'(w);
    v.fl = 1'(f);    v.rv = 1'(rv);
    v.rd = 5'(rd);
    v.e_stall = 1'(es); v.e_issue = 1'(ei);
    v.e_busy = 32'(eb); v.e_infl = 7'(en);
    v.e_sc = 16'(ec);   v.e_err = 1'(ee);
    return v;
  endfunction

  task automatic drv(input vec_t v);
    rst = v.rst;       id_valid = v.idv;
    src1 = v.s1;       src1_used = v.s1u;
    src2 = v.s2;       src2_used = v.s2u;
    dest = v.d;        wb_en = v.wb;
    flush = v.fl;      ret_valid = v.rv;
    ret_dest = v.rd;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input int i, input vec_t v);
    string p;
    p = $sformatf("row%0d", i);
    chk({p, ".stall"}, 32'(stall), 32'(v.e_stall));
    chk({p, ".issue"}, 32'(issue), 32'(v.e_issue));
    chk({p, ".busy"}, busy, v.e_busy);
    chk({p, ".inflight"}, 32'(inflight), 32'(v.e_infl));
    chk({p, ".stall_cycles"}, 32'(stall_cycles), 32'(v.e_sc));
    chk({p, ".err"}, 32'(err), 32'(v.e_err));
  endtask

  initial begin
    // rst iv s1 u s2 u d wb fl rv rd | st is busy infl sc err
    vq.push_back(mk(0,1, 3,1, 0,0, 4,1,0,1, 9, 0,1,'h0,0,0,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,'h0,0,0,0));
    vq.push_back(mk(1,1, 1,1, 2,1, 5,1,0,0, 0, 0,1,'h0,0,0,0));
    vq.push_back(mk(1,1, 5,1, 6,1, 8,1,0,0, 0, 1,0,'h20,1,0,0));
    vq.push_back(mk(1,1, 5,1, 6,1, 8,1,0,0, 0, 1,0,'h20,1,1,0));
    vq.push_back(mk(1,1, 5,1, 6,1, 8,1,0,1, 5, 0,1,'h20,1,2,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,'h100,1,2,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,1, 8, 0,0,'h100,1,2,0));
    vq.push_back(mk(1,1, 0,0, 0,0, 5,1,0,0, 0, 0,1,'h0,0,2,0));
    vq.push_back(mk(1,1, 0,1, 5,0, 0,1,0,0, 0, 0,1,'h20,1,2,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,'h20,1,2,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,1, 5, 0,0,'h20,1,2,0));
    vq.push_back(mk(1,1, 0,0, 0,0, 7,1,0,0, 0, 0,1,'h0,0,2,0));
    vq.push_back(mk(1,1, 0,0, 0,0, 7,1,0,0, 0, 0,1,'h80,1,2,0));
    vq.push_back(mk(1,1, 0,0, 0,0, 7,1,0,0, 0, 0,1,'h80,2,2,0));
    vq.push_back(mk(1,1, 0,0, 0,0, 7,1,0,1, 7, 1,0,'h80,3,2,0));
    vq.push_back(mk(1,1, 0,0, 0,0, 7,1,0,1, 7, 0,1,'h80,2,3,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,'h80,2,3,0));
    vq.push_back(mk(1,1, 7,1, 0,0, 7,1,1,0, 0, 0,0,'h80,2,3,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,'h80,2,3,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,1, 7, 0,0,'h80,2,3,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,1, 7, 0,0,'h80,1,3,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,1, 9, 0,0,'h0,0,3,0));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,'h0,0,3,1));
    vq.push_back(mk(1,1, 9,1, 0,0,10,1,0,0, 0, 0,1,'h0,0,3,1));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,'h400,1,3,1));
    vq.push_back(mk(0,1,10,1, 0,0, 0,0,0,0, 0, 1,0,'h400,1,3,1));
    vq.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,'h0,0,0,0));

    drv(mk(0,1,3,1,4,1,6,1,0,1,2, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1 drv(vq[i]);
      @(negedge clk);
      chk_row(i, vq[i]);
    end

    // Long hold: producer to r12, consumer waits five cycles.
    @(posedge clk);
    #1 drv(mk(1,1,0,0,0,0,12,1,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    chk("seq.producer_issue", 32'(issue), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 drv(mk(1,1,0,0,12,1,0,0,0,0,0, 0,0,0,0,0,0));
      @(negedge clk);
      chk($sformatf("seq.hold%0d", k), 32'(stall), 32'd1);
      chk($sformatf("seq.sc%0d", k), 32'(stall_cycles), 32'(k));
    end
    @(posedge clk);
    #1 drv(mk(1,1,0,0,12,1,0,0,0,1,12, 0,0,0,0,0,0));
    @(negedge clk);
    chk("seq.release_issue", 32'(issue), 32'd1);
    chk("seq.release_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 drv(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    chk("seq.final_sc", 32'(stall_cycles), 32'd5);
    chk("seq.final_inflight", 32'(inflight), 32'd0);
    chk("seq.final_busy", busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_scoreboard.md
# id_hazard_scoreboard

Register scoreboard and issue controller for the decode stage of the 5-stage pipeline. It tracks register-file writes that are in flight between decode and write-back and holds the decode stage while an instruction reads a register with a pending write. It also reports per-register busy state, the in-flight writer count, and stall statistics. It sits beside the decode logic: it takes source/destination fields and write enables from the decoder and retirements from the write-back port.

## Interface
- CNT_W, 2: width of each per-register pending counter; at most 2^CNT_W-1 in-flight writers per register.
- STALL_W, 16: width of the stall-cycle counter.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets).
- id_valid  in  1  a valid instruction sits in decode.
- src1  in  5  first source register (instruction[25:21]).
- src1_used  in  1  instruction reads src1.
- src2  in  5  second source register (instruction[20:16]).
- src2_used  in  1  instruction reads src2 as a register (R-type, ST, BNE).
- dest  in  5  destination register of the decode instruction.
- wb_en  in  1  decode instruction writes dest.
- flush  in  1  branch taken in EXE; the decode instruction is discarded.
- ret_valid  in  1  write-back writes the register file this cycle.
- ret_dest  in  5  write-back destination.
- stall  out  1  hold IF and the IF/ID register; inject a bubble into ID/EXE.
- issue  out  1  decode instruction advances to EXE this cycle.
- busy  out  32  bit r = 1 when register r has a pending count != 0; bit 0 is always 0.
- inflight  out  7  sum of all pending counters.
- stall_cycles  out  STALL_W  saturating count of cycles with stall=1.
- err  out  1  sticky; set on a retire to a register whose count is 0.

## Operation
- State per register r in 1..31: pend[r], a CNT_W-bit counter. Register 0 is never tracked; any dest or src of 0 is ignored.
- Write-back writes the register file on the falling edge, so a same-cycle retire is visible to decode.
  - Effective pending for source s: eff(s) = pend[s] - (ret_valid && ret_dest==s ? 1 : 0).
- Hazard conditions:
  - raw = (src1_used && src1!=0 && eff(src1)!=0) || (src2_used && src2!=0 && eff(src2)!=0).
  - sat = wb_en && dest!=0 && pend[dest]==max, where max = 2^CNT_W-1. This is a structural stall; a same-cycle retire to dest does not clear it.
- Outputs:
  - stall = id_valid && !flush && (raw || sat).
  - issue = id_valid && !flush && !stall.
- Counter update at each rising edge, for each r:
  - inc = issue && wb_en && dest==r && r!=0.
  - dec = ret_valid && ret_dest==r && r!=0 && pend[r]!=0.
  - inc && dec: count unchanged. inc only: +1. dec only: -1.
  - A retire to r with pend[r]==0 (r!=0) sets err and leaves the count at 0 (no underflow).
- inflight is combinational from the pend[] array (max 93 at CNT_W=2).
- stall_cycles increments on every cycle with stall=1 and saturates at all ones.
- flush has priority over hazards. It forces stall=0 and issue=0 and never modifies counters. Instructions already issued still retire normally.

## Timing
- stall, issue and busy are combinational from the current inputs and state; there is no added latency in the decode cycle.
- Counter, err and stall_cycles updates take effect one cycle after the causing edge.
- Reset (rst=0 at a rising edge) clears:
  - all pend[] to 0, so busy=0 and inflight=0;
  - err to 0;
  - stall_cycles to 0.
- Reset in the middle of operation discards all in-flight tracking. The pipeline is reset in the same cycle.
- During reset cycles, stall and issue still evaluate combinationally against the cleared state from the next edge on.
- Typical dependent pair with no forwarding: the producer issues at cycle t.
  - The consumer stalls at t+1 and t+2 and issues at t+3, the cycle the producer retires at WB.
  - That is 2 stall cycles (producer sits in EXE at t+1, MEM at t+2, WB at t+3).

## Test plan
- Reset: hold rst=0 for 2 cycles with arbitrary inputs -> busy=0, inflight=0, err=0, stall_cycles=0, stall=0.
- RAW: issue ADD with dest=5 at t; at t+1 present SUB with src1=5 -> stall=1 at t+1 and t+2; at t+3 drive ret_valid with ret_dest=5 -> stall=0, issue=1; stall_cycles=2; pend[5]=0 after t+3.
- Imm/zero ignore: pend[5]=1, instruction with src2=5, src2_used=0 -> no stall. dest=0 with wb_en=1 issued -> inflight unchanged, busy[0]=0.
- Saturation and simultaneous events: issue 3 writes to r7 -> pend=3; fourth writer to r7 -> stall=1 even with a same-cycle retire to r7; next cycle pend=2 and it issues; issue plus retire to r7 in the same cycle -> pend stays 2.
- Flush: id_valid=1, hazard present, flush=1 -> stall=0, issue=0, counters unchanged, stall_cycles not incremented.
- Error: ret_valid with ret_dest=9 and pend[9]=0 -> err=1 next cycle and stays 1 until rst=0; pend[9] stays 0.
